// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control and result bus of the truth-table sweeper
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] table_code;
    logic       match;
    logic [7:0] unstable;

    modport master (
        output start, abort,
        input  busy, done, table_code, match, unstable
    );

    modport slave (
        input  start, abort,
        output busy, done, table_code, match, unstable
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all 8 rows of a 3-input circuit and recovers its truth-table code
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         SAMPLES       = 3,
    parameter logic [7:0] EXPECTED      = 8'h92
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweeper_if.slave bus,
    input  logic                 sample_out,
    output logic                 drive_in1,
    output logic                 drive_in2,
    output logic                 drive_in3
);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0]     code_q, code_d;
    logic [7:0]     unst_q, unst_d;
    logic           match_q, match_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2:0]     bit_idx;

    // Row r lands in bit 7-r so that row 000 is the MSB of the code.
    assign bit_idx = 3'd7 - row_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        sync1_d = sample_out;
        sync2_d = sync1_q;
        code_d  = code_q;
        unst_d  = unst_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    code_d  = 8'h00;
                    unst_d  = 8'h00;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    code_d  = 8'h00;
                    unst_d  = 8'h00;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    code_d  = 8'h00;
                    unst_d  = 8'h00;
                    busy_d  = 1'b0;
                end else begin
                    if (cnt_q == '0) begin
                        code_d[bit_idx] = sync2_q;
                    end else if (sync2_q != code_q[bit_idx]) begin
                        unst_d[bit_idx] = 1'b1;
                    end
                    if (cnt_q == CNT_W'(SAMPLES - 1)) begin
                        cnt_d = '0;
                        if (row_q == 3'd7) begin
                            // Judged on the next-state values so the final sample counts.
                            state_d = DONE;
                            row_d   = 3'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            match_d = (code_d == EXPECTED) && (unst_d == 8'h00);
                        end else begin
                            state_d = DRIVE;
                            row_d   = row_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            code_q  <= 8'h00;
            unst_q  <= 8'h00;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            code_q  <= code_d;
            unst_q  <= unst_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign drive_in1      = row_q[2];
    assign drive_in2      = row_q[1];
    assign drive_in3      = row_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.table_code = code_q;
    assign bus.unstable   = unst_q;
    assign bus.match      = match_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r = 1'b0;
    logic       abort_r = 1'b0;
    logic       glitch  = 1'b0;
    logic       mode    = 1'b0;
    logic [1:0] sel     = 2'd0;

    truth_table_sweeper_if bus0 ();
    truth_table_sweeper_if bus1 ();
    truth_table_sweeper_if bus2 ();

    logic [2:0] drv0, drv1, drv2;
    logic       so0, so1, so2;
    logic [2:0] pa = 3'b000;
    logic [2:0] pb = 3'b000;

    function automatic logic model(input logic m, input logic [2:0] r);
        if (m) return r[2] & r[1] & r[0];
        return (~r[2] & (r[1] ~^ r[0])) | (r[2] & r[1] & ~r[0]);
    endfunction

    assign so0 = model(mode, drv0) ^ glitch;
    always @(posedge clk) begin
        pa <= {pa[1:0], model(1'b0, drv1)};
        pb <= {pb[1:0], model(1'b0, drv2)};
    end
    assign so1 = pa[2];
    assign so2 = pb[2];

    assign bus0.start = start_r && (sel == 2'd0);
    assign bus1.start = start_r && (sel == 2'd1);
    assign bus2.start = start_r && (sel == 2'd2);
    assign bus0.abort = abort_r && (sel == 2'd0);
    assign bus1.abort = abort_r && (sel == 2'd1);
    assign bus2.abort = abort_r && (sel == 2'd2);

    truth_table_sweeper dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sample_out(so0),
        .drive_in1(drv0[2]), .drive_in2(drv0[1]), .drive_in3(drv0[0])
    );
    truth_table_sweeper #(.SETTLE_CYCLES(5)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sample_out(so1),
        .drive_in1(drv1[2]), .drive_in2(drv1[1]), .drive_in3(drv1[0])
    );
    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .sample_out(so2),
        .drive_in1(drv2[2]), .drive_in2(drv2[1]), .drive_in3(drv2[0])
    );

    logic       m_busy, m_done, m_match;
    logic [7:0] m_code, m_unst;
    logic [2:0] m_drv;
    always_comb begin
        m_busy = bus0.busy; m_done = bus0.done; m_match = bus0.match;
        m_code = bus0.table_code; m_unst = bus0.unstable; m_drv = drv0;
        case (sel)
            2'd1: begin
                m_busy = bus1.busy; m_done = bus1.done; m_match = bus1.match;
                m_code = bus1.table_code; m_unst = bus1.unstable; m_drv = drv1;
            end
            2'd2: begin
                m_busy = bus2.busy; m_done = bus2.done; m_match = bus2.match;
                m_code = bus2.table_code; m_unst = bus2.unstable; m_drv = drv2;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [7:0] code;
        logic [7:0] unst;
        logic       match;
        logic       loose;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({m_busy, m_done, m_match} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got %b want 000", {m_busy, m_done, m_match});
        end
        checks++;
        if ({m_code, m_unst} !== 16'h0000) begin
            fails++; $display("FAIL reset_results got %h want 0000", {m_code, m_unst});
        end
        checks++;
        if (m_drv !== 3'b000) begin
            fails++; $display("FAIL reset_drive got %b want 000", m_drv);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sweep(input logic [1:0] s, input logic m, input int lat,
                             input int restart_at, input logic with_abort,
                             input logic [7:0] ecode, input logic [7:0] eunst,
                             input logic ematch, input logic loose, input int glitch_at);
        exp_t e;
        int   n;
        logic seen, busy_ok;
        sel  = s;
        mode = m;
        e = '{code: ecode, unst: eunst, match: ematch, loose: loose};
        sb.push_back(e);
        @(negedge clk);
        start_r = 1'b1;
        abort_r = with_abort;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        abort_r = 1'b0;
        checks++;
        if (m_busy !== 1'b1 || m_drv !== 3'b000) begin
            fails++; $display("FAIL start_edge busy/drv got %b/%b want 1/000", m_busy, m_drv);
        end
        checks++;
        if ({m_code, m_unst, m_match} !== 17'h0) begin
            fails++; $display("FAIL start_clear got %h/%h/%b want 00/00/0", m_code, m_unst, m_match);
        end
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (n < 300 && !seen) begin
            @(negedge clk);
            start_r = (n + 1 == restart_at);
            glitch  = (n + 1 == glitch_at);
            @(posedge clk);
            n++;
            #1;
            if (m_done) seen = 1'b1;
            else if (!m_busy) busy_ok = 1'b0;
        end
        start_r = 1'b0;
        glitch  = 1'b0;
        checks++;
        if (!seen || n != lat) begin
            fails++; $display("FAIL done_latency got %0d (seen=%b) want %0d", n, seen, lat);
        end
        checks++;
        if (!busy_ok || m_busy !== 1'b0) begin
            fails++; $display("FAIL busy_window dropped_early=%b busy_at_done=%b want 0/0", !busy_ok, m_busy);
        end
        checks++;
        if (m_drv !== 3'b000) begin
            fails++; $display("FAIL done_drive got %b want 000", m_drv);
        end
        if (sb.size() == 0) begin
            checks++; fails++; $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (e.loose) begin
                checks++;
                if (m_match !== 1'b0 || (m_code === 8'h92 && m_unst === 8'h00)) begin
                    fails++; $display("FAIL short_settle got code=%h unst=%h match=%b want mismatch", m_code, m_unst, m_match);
                end
            end else begin
                checks++;
                if (m_code !== e.code) begin
                    fails++; $display("FAIL table_code got %h want %h", m_code, e.code);
                end
                checks++;
                if (m_unst !== e.unst) begin
                    fails++; $display("FAIL unstable got %h want %h", m_unst, e.unst);
                end
                checks++;
                if (m_match !== e.match) begin
                    fails++; $display("FAIL match got %b want %b", m_match, e.match);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_done !== 1'b0 || (!e.loose && m_code !== e.code)) begin
            fails++; $display("FAIL done_pulse_hold done=%b code=%h want 0/%h", m_done, m_code, e.code);
        end
    endtask

    task automatic test_abort();
        int  k;
        logic done_seen;
        sel  = 2'd0;
        mode = 1'b0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        checks++;
        if (m_drv !== 3'b011 || m_code !== 8'h80) begin
            fails++; $display("FAIL abort_pre drv=%b code=%h want 011/80", m_drv, m_code);
        end
        @(negedge clk);
        abort_r = 1'b1;
        start_r = 1'b1;
        @(posedge clk);
        #1;
        abort_r = 1'b0;
        start_r = 1'b0;
        checks++;
        if ({m_busy, m_done, m_drv} !== 5'b0 || {m_code, m_unst} !== 16'h0) begin
            fails++; $display("FAIL abort_state busy=%b done=%b drv=%b code=%h unst=%h want all 0",
                              m_busy, m_done, m_drv, m_code, m_unst);
        end
        done_seen = 1'b0;
        for (k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (m_done || m_busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            fails++; $display("FAIL abort_no_done got activity=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        sel  = 2'd0;
        mode = 1'b0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        checks++;
        if (m_drv !== 3'b101 || m_code !== 8'h90) begin
            fails++; $display("FAIL reset_pre drv=%b code=%h want 101/90", m_drv, m_code);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_busy, m_done, m_match, m_drv} !== 6'b0 || {m_code, m_unst} !== 16'h0) begin
            fails++; $display("FAIL reset_async busy=%b done=%b match=%b drv=%b code=%h unst=%h want all 0",
                              m_busy, m_done, m_match, m_drv, m_code, m_unst);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] e92, eand;
        e92 = 8'h00; eand = 8'h00;
        for (int r = 0; r < 8; r++) begin
            e92[7-r]  = model(1'b0, 3'(r));
            eand[7-r] = model(1'b1, 3'(r));
        end
        test_reset();
        run_sweep(2'd0, 1'b0, 56, -1, 1'b0, e92,  8'h00, 1'b1, 1'b0, -1);
        run_sweep(2'd0, 1'b1, 56, -1, 1'b0, eand, 8'h00, 1'b0, 1'b0, -1);
        run_sweep(2'd0, 1'b0, 56, -1, 1'b0, e92,  8'h00, 1'b1, 1'b0, -1);
        run_sweep(2'd0, 1'b0, 56, -1, 1'b0, e92,  8'h08, 1'b0, 1'b0, 33);
        test_abort();
        run_sweep(2'd0, 1'b0, 56, -1, 1'b1, e92,  8'h00, 1'b1, 1'b0, -1);
        test_reset_mid();
        run_sweep(2'd0, 1'b1, 56, 20, 1'b0, eand, 8'h00, 1'b0, 1'b0, -1);
        run_sweep(2'd1, 1'b0, 64, -1, 1'b0, e92,  8'h00, 1'b1, 1'b0, -1);
        run_sweep(2'd2, 1'b0, 40, -1, 1'b0, e92,  8'h00, 1'b0, 1'b1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
